// File: rtl/bsg_arb_rr_burst_lock.sv
// Round-robin arbiter that locks the shared channel to one requester for a multi-beat burst.
// Grants are combinational from the requests and the registered IDLE/LOCKED state.
module bsg_arb_rr_burst_lock #(
  parameter int inputs_p    = 4,
  parameter int max_burst_p = 8,
  localparam int lg_inputs_lp = $clog2(inputs_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [inputs_p-1:0]     reqs_i,
  input  logic                    last_i,
  input  logic                    ready_i,
  output logic [inputs_p-1:0]     grants_o,
  output logic                    v_o,
  output logic [lg_inputs_lp-1:0] grant_id_o,
  output logic                    locked_o
);

  localparam int beats_w_lp = $clog2(max_burst_p + 1);
  localparam logic [beats_w_lp-1:0] max_beats_lp = beats_w_lp'(max_burst_p);

  localparam logic [0:0] idle_s   = 1'b0;
  localparam logic [0:0] locked_s = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [lg_inputs_lp-1:0] ptr_q, ptr_d;
  logic [lg_inputs_lp-1:0] owner_q, owner_d;
  logic [beats_w_lp-1:0]   beats_q, beats_d;

  logic                    found;
  logic [lg_inputs_lp-1:0] winner;
  logic                    xfer;
  logic [lg_inputs_lp-1:0] sel_id;
  logic [beats_w_lp-1:0]   beats_inc;

  function automatic logic [lg_inputs_lp-1:0] next_idx(input logic [lg_inputs_lp-1:0] cur);
    int n;
    n = int'(cur) + 1;
    if (n >= inputs_p) n = 0;
    return lg_inputs_lp'(n);
  endfunction

  // Scan from the highest offset down so the lowest offset from ptr_q wins.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = inputs_p - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= inputs_p) idx = idx - inputs_p;
      if (reqs_i[lg_inputs_lp'(idx)]) begin
        found  = 1'b1;
        winner = lg_inputs_lp'(idx);
      end
    end
  end

  always_comb begin
    xfer   = 1'b0;
    sel_id = '0;
    if (!reset_i) begin
      if (state_q == locked_s) begin
        xfer   = reqs_i[owner_q] & ready_i;
        sel_id = owner_q;
      end else begin
        xfer   = found & ready_i;
        sel_id = winner;
      end
    end
    grants_o   = '0;
    grant_id_o = '0;
    if (xfer) begin
      grants_o[sel_id] = 1'b1;
      grant_id_o       = sel_id;
    end
    v_o = xfer;
  end

  assign beats_inc = beats_q + beats_w_lp'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beats_d = beats_q;
    if (xfer) begin
      if (state_q == idle_s) begin
        if (last_i || (max_burst_p == 1)) begin
          ptr_d = next_idx(winner);
        end else begin
          state_d = locked_s;
          owner_d = winner;
          beats_d = beats_w_lp'(1);
        end
      end else begin
        beats_d = beats_inc;
        // The max-length cutoff ends the lock even if the requester never signals last.
        if (last_i || (beats_inc == max_beats_lp)) begin
          state_d = idle_s;
          ptr_d   = next_idx(owner_q);
          beats_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= idle_s;
      ptr_q   <= '0;
      owner_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
    end
  end

  assign locked_o = (state_q == locked_s);

endmodule

// File: tb/tb_bsg_arb_rr_burst_lock.sv
// Directed bench for bsg_arb_rr_burst_lock with inputs_p=4, max_burst_p=4.
// A vector table covers fairness, lock and max-burst cutoff; hand sequences cover stall, backpressure and reset.
module tb_bsg_arb_rr_burst_lock;

  typedef struct {
    logic [3:0] reqs;
    logic       last;
    logic       ready;
    logic       rst;
    logic [3:0] exp_grants;
    logic [1:0] exp_id;
    logic       exp_locked;
    logic       chk_locked;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] reqs_i;
  logic       last_i;
  logic       ready_i;
  logic [3:0] grants_o;
  logic       v_o;
  logic [1:0] grant_id_o;
  logic       locked_o;

  int total = 0;
  int bad   = 0;

  vec_t vecs[22];

  bsg_arb_rr_burst_lock #(
    .inputs_p   (4),
    .max_burst_p(4)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .reqs_i    (reqs_i),
    .last_i    (last_i),
    .ready_i   (ready_i),
    .grants_o  (grants_o),
    .v_o       (v_o),
    .grant_id_o(grant_id_o),
    .locked_o  (locked_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [3:0] exp_grants,
                             input logic [1:0] exp_id, input logic exp_locked,
                             input logic chk_locked);
    total++;
    if (grants_o !== exp_grants) begin
      bad++;
      $display("[TB] FAIL %s grants: got %b expected %b", name, grants_o, exp_grants);
    end
    total++;
    if (v_o !== (|exp_grants)) begin
      bad++;
      $display("[TB] FAIL %s v: got %b expected %b", name, v_o, |exp_grants);
    end
    total++;
    if (grant_id_o !== exp_id) begin
      bad++;
      $display("[TB] FAIL %s grant_id: got %0d expected %0d", name, grant_id_o, exp_id);
    end
    if (chk_locked) begin
      total++;
      if (locked_o !== exp_locked) begin
        bad++;
        $display("[TB] FAIL %s locked: got %b expected %b", name, locked_o, exp_locked);
      end
    end
  endtask

  // Drive one cycle, check the combinational outputs mid-cycle, then step past the edge.
  task automatic applyStimulus(input string name, input logic [3:0] reqs, input logic last,
                               input logic ready, input logic rst,
                               input logic [3:0] exp_grants, input logic [1:0] exp_id,
                               input logic exp_locked, input logic chk_locked);
    reqs_i  = reqs;
    last_i  = last;
    ready_i = ready;
    reset_i = rst;
    #2;
    checkOutput(name, exp_grants, exp_id, exp_locked, chk_locked);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    reqs_i  = 4'b0000;
    last_i  = 1'b0;
    ready_i = 1'b0;

    // reqs, last, ready, rst, grants, id, locked-before-edge, check-locked
    vecs[0]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1};
    vecs[3]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1};
    vecs[4]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b1};
    vecs[5]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b1};
    vecs[6]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1};
    vecs[7]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1};
    vecs[8]  = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1};
    vecs[9]  = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[10] = '{4'b0011, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[11] = '{4'b0011, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1};
    vecs[12] = '{4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b1};
    vecs[13] = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1};
    vecs[14] = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[15] = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[16] = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[17] = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b1};
    vecs[18] = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[19] = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[20] = '{4'b0101, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[21] = '{4'b0101, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1};

    @(negedge clk_i);
    for (int i = 0; i < 22; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].reqs, vecs[i].last, vecs[i].ready,
                    vecs[i].rst, vecs[i].exp_grants, vecs[i].exp_id, vecs[i].exp_locked,
                    vecs[i].chk_locked);
    end

    // Owner 1 locks, drops its request for three cycles, then finishes; ptr lands on 2.
    applyStimulus("stall_lock", 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("stall%0d", i), 4'b1100, 1'b0, 1'b1, 1'b0,
                    4'b0000, 2'd0, 1'b1, 1'b1);
    end
    applyStimulus("stall_end", 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1);
    applyStimulus("stall_next", 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b1);

    // Backpressure on requester 3, then a granted last beat wraps ptr to 0.
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("bp%0d", i), 4'b1000, 1'b1, 1'b0, 1'b0,
                    4'b0000, 2'd0, 1'b0, 1'b1);
    end
    applyStimulus("bp_go", 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, 1'b1);
    applyStimulus("bp_wrap", 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1);

    // Requester 2 locks for two beats, then reset abandons the burst.
    applyStimulus("rst_lock0", 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b1);
    applyStimulus("rst_lock1", 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1);
    applyStimulus("rst_mid", 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus("rst_after", 4'b1111, 1'b1, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
